// File: rtl/uart_pkg.sv
// uart_pkg: shared state encodings, parity codes and limits for the UART transmitter.
package uart_pkg;
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } state_e;
   typedef enum logic [1:0] {
      PAR_NONE = 2'b00,
      PAR_EVEN = 2'b01,
      PAR_ODD  = 2'b10
   } par_e;
   localparam int UART_MIN_DATA_BITS = 5;
endpackage

// File: rtl/uart_tx_bit_timer.sv
// uart_tx_bit_timer: counts oversampling ticks and pulses o_bit_end on the last tick of a bit.
module uart_tx_bit_timer #(
   parameter int TICKS_PER_BIT = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_tick_en,
   input  logic i_clr,
   output logic o_bit_end
);
   localparam int CW = $clog2(TICKS_PER_BIT);
   logic [CW-1:0] cnt_q, cnt_d;
   logic          wrap;
   assign wrap      = cnt_q == CW'(TICKS_PER_BIT - 1);
   assign o_bit_end = i_tick_en && wrap && !i_clr;
   always_comb begin
      cnt_d = i_clr ? '0 : i_tick_en ? (wrap ? '0 : cnt_q + CW'(1)) : cnt_q;
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART transmitter (length, parity, stop bits).
// Parity support is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_cfg
   import uart_pkg::*;
#(
   parameter int DATA_BITS     = 8,
   parameter int TICKS_PER_BIT = 16
) (
   input  logic                           i_clk,
   input  logic                           i_rst_n,
   input  logic                           i_tick_en,
   input  logic                           i_valid,
   output logic                           o_ready,
   input  logic [DATA_BITS-1:0]           i_data,
   input  logic [$clog2(DATA_BITS+1)-1:0] i_cfg_len,
   input  logic [1:0]                     i_cfg_parity,
   input  logic                           i_cfg_stop,
   output logic                           o_tx,
   output logic                           o_busy,
   output logic                           o_tx_done
);
   localparam int LW = $clog2(DATA_BITS + 1);
   state_e               state_q, state_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic [LW-1:0]        len_q, len_d, bit_q, bit_d, len_in;
   logic                 stop_q, stop_d, bit_end, last_data, done;
`ifdef UART_TX_PARITY_EN
   par_e                 par_mode_q, par_mode_d;
   logic                 par_q, par_d, par_bit;
   assign par_bit = par_q ^ (par_mode_q == PAR_ODD);
`else
   logic                 unused_parity;
   assign unused_parity = ^i_cfg_parity;
`endif
   assign o_ready   = state_q == IDLE;
   assign o_busy    = !o_ready;
   assign o_tx_done = done;
   assign last_data = bit_q == len_q - LW'(1);
   assign len_in    = (i_cfg_len < LW'(UART_MIN_DATA_BITS)) ? LW'(UART_MIN_DATA_BITS)
                    : (i_cfg_len > LW'(DATA_BITS)) ? LW'(DATA_BITS) : i_cfg_len;
`ifdef UART_TX_PARITY_EN
   assign o_tx = (state_q == START) ? 1'b0 : (state_q == DATA) ? shift_q[0]
               : (state_q == PARITY) ? par_bit : 1'b1;
`else
   assign o_tx = (state_q == START) ? 1'b0 : (state_q == DATA) ? shift_q[0] : 1'b1;
`endif
   // The timer is held clear while idle, so a tick on the accept cycle is never counted.
   uart_tx_bit_timer #(.TICKS_PER_BIT(TICKS_PER_BIT)) u_timer (
      .i_clk     (i_clk),
      .i_rst_n   (i_rst_n),
      .i_tick_en (i_tick_en),
      .i_clr     (o_ready),
      .o_bit_end (bit_end)
   );
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      len_d   = len_q;
      bit_d   = bit_q;
      stop_d  = stop_q;
      done    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_mode_d = par_mode_q;
      par_d      = par_q;
`endif
      case (state_q)
         IDLE: if (i_valid) begin
            state_d = START;
            shift_d = i_data;
            len_d   = len_in;
            stop_d  = i_cfg_stop;
            bit_d   = '0;
`ifdef UART_TX_PARITY_EN
            par_d      = 1'b0;
            par_mode_d = (i_cfg_parity == PAR_EVEN || i_cfg_parity == PAR_ODD) ? par_e'(i_cfg_parity) : PAR_NONE;
`endif
         end
         START: if (bit_end) state_d = DATA;
         DATA: if (bit_end) begin
            shift_d = shift_q >> 1;
            bit_d   = last_data ? '0 : bit_q + LW'(1);
`ifdef UART_TX_PARITY_EN
            par_d = par_q ^ shift_q[0];
            if (last_data) state_d = (par_mode_q == PAR_NONE) ? STOP : PARITY;
`else
            if (last_data) state_d = STOP;
`endif
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (bit_end) state_d = STOP;
`endif
         STOP: if (bit_end) begin
            done    = bit_q == LW'(stop_q);
            state_d = done ? IDLE : STOP;
            bit_d   = done ? '0 : bit_q + LW'(1);
         end
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         len_q   <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
         par_mode_q <= PAR_NONE;
         par_q      <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         len_q   <= len_d;
         bit_q   <= bit_d;
         stop_q  <= stop_d;
`ifdef UART_TX_PARITY_EN
         par_mode_q <= par_mode_d;
         par_q      <= par_d;
`endif
      end
   end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: scoreboard bench; frames are captured per tick and compared to hand-written bit strings.
module tb_uart_tx_cfg;
   localparam int TPB = 16;
   logic       clk = 1'b0;
   logic       rst_n, tick, valid, o_ready, o_tx, o_busy, o_tx_done, stop;
   logic [7:0] data;
   logic [3:0] len;
   logic [1:0] par;
   int         tests = 0, fails = 0;
   int         tick_div = 1, cyc = 0;
   bit         pause = 0;
   string      exp_bits[$];
   int         exp_ticks[$], exp_gap[$];
   bit         in_frame = 0, glitch = 0, cur = 1;
   string      got;
   int         tcnt = 0, idle_run = 0, gap = 0, fidx = 0;

   uart_tx_cfg #(.DATA_BITS(8), .TICKS_PER_BIT(TPB)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_tick_en(tick), .i_valid(valid), .o_ready(o_ready),
      .i_data(data), .i_cfg_len(len), .i_cfg_parity(par), .i_cfg_stop(stop),
      .o_tx(o_tx), .o_busy(o_busy), .o_tx_done(o_tx_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      cyc++;
      tick = !pause && (cyc % tick_div == 0);
   end

   task automatic chk_int(input string nm, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_str(input string nm, input string act, input string exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %s expected %s", nm, act, exp);
      end
   endtask

   // Monitor: samples the line on every counted tick and scores a frame at o_tx_done.
   always @(negedge clk) begin
      if (!rst_n) begin
         in_frame = 0;
         idle_run = 0;
      end else begin
         if (o_busy && !in_frame) begin
            in_frame = 1; got = ""; tcnt = 0; cur = 1; glitch = 0; gap = idle_run;
         end
         idle_run = o_ready ? idle_run + 1 : 0;
         if (o_ready == o_busy) glitch = 1;
         if (in_frame && tick) begin
            if (tcnt % TPB == 0) begin
               cur = o_tx;
               got = $sformatf("%s%0d", got, o_tx);
            end else if (o_tx !== cur) glitch = 1;
            tcnt++;
         end
         if (o_tx_done) begin
            if (!in_frame || exp_bits.size() == 0) chk_int("spurious_done", 1, 0);
            else begin
               string eb;
               int    et, eg;
               eb = exp_bits.pop_front();
               et = exp_ticks.pop_front();
               eg = exp_gap.pop_front();
               chk_str($sformatf("f%0d_bits", fidx), got, eb);
               chk_int($sformatf("f%0d_ticks", fidx), tcnt, et);
               chk_int($sformatf("f%0d_stable", fidx), glitch, 0);
               if (eg >= 0) chk_int($sformatf("f%0d_gap", fidx), gap, eg);
            end
            fidx++;
            in_frame = 0;
         end
      end
   end

   task automatic send(input logic [7:0] d, input logic [3:0] l, input logic [1:0] p, input logic s,
                       input string bits, input int ticks, input bit push);
      int n = 0;
      @(negedge clk);
      while (!o_ready && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (!o_ready) chk_int("ready_timeout", 0, 1);
      data = d; len = l; par = p; stop = s; valid = 1;
      if (push) begin
         exp_bits.push_back(bits);
         exp_ticks.push_back(ticks);
         exp_gap.push_back(-1);
      end
      @(posedge clk);
      #1 valid = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((o_busy || exp_bits.size() != 0) && n < 5000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 5000) begin
         chk_int("frame_timeout", 0, 1);
         exp_bits.delete(); exp_ticks.delete(); exp_gap.delete();
      end
   endtask

   task automatic frame(input logic [7:0] d, input logic [3:0] l, input logic [1:0] p, input logic s,
                        input string bits, input int ticks);
      send(d, l, p, s, bits, ticks, 1);
      wait_idle();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      rst_n = 1; valid = 0; data = 0; len = 8; par = 0; stop = 0;
      #2 rst_n = 0; valid = 1; data = 8'hA5;
      repeat (3) @(negedge clk);
      chk_int("rst_tx", o_tx, 1);
      chk_int("rst_ready", o_ready, 1);
      chk_int("rst_busy", o_busy, 0);
      chk_int("rst_done", o_tx_done, 0);
      valid = 0;
      rst_n = 1;
      frame(8'hA5, 8, 2'b00, 0, "0101001011", 160);
`ifdef UART_TX_PARITY_EN
      frame(8'h53, 7, 2'b01, 0, "0110010101", 160);
      frame(8'h53, 7, 2'b10, 0, "0110010111", 160);
`else
      frame(8'h53, 7, 2'b01, 0, "011001011", 144);
      frame(8'h53, 7, 2'b10, 0, "011001011", 144);
`endif
      frame(8'h53, 7, 2'b11, 0, "011001011", 144);
      frame(8'h0F, 15, 2'b00, 0, "0111100001", 160);
      tick_div = 4;
      frame(8'hFF, 5, 2'b00, 1, "01111111", 128);
      frame(8'hFF, 3, 2'b00, 1, "01111111", 128);
      tick_div = 1;
      // Back-to-back: i_valid held, length changed while frame 1 is on the line.
      begin
         int n = 0;
         @(negedge clk);
         data = 8'h31; len = 8; par = 0; stop = 0; valid = 1;
         exp_bits.push_back("0100011001"); exp_ticks.push_back(160); exp_gap.push_back(-1);
         exp_bits.push_back("00100111");   exp_ticks.push_back(128); exp_gap.push_back(1);
         @(posedge clk);
         #1 data = 8'h32; len = 6;
         while (exp_bits.size() > 1 && n < 5000) begin
            @(posedge clk);
            n++;
         end
         @(posedge clk);
         #1 valid = 0;
         wait_idle();
      end
      // Tick pause during data bit 1 of 0xA5 (a 0 bit).
      send(8'hA5, 8, 2'b00, 0, "0101001011", 160, 1);
      repeat (40) @(posedge clk);
      @(negedge clk) pause = 1;
      repeat (2) @(negedge clk);
      chk_int("pause_tx_start", o_tx, 0);
      repeat (100) @(negedge clk);
      chk_int("pause_tx_end", o_tx, 0);
      chk_int("pause_busy", o_busy, 1);
      pause = 0;
      wait_idle();
      // Reset in the middle of a zero data byte.
      send(8'h00, 8, 2'b00, 0, "", 0, 0);
      repeat (40) @(posedge clk);
      #3 chk_int("abort_pre_tx", o_tx, 0);
      rst_n = 0;
      #1 chk_int("abort_tx", o_tx, 1);
      chk_int("abort_ready", o_ready, 1);
      chk_int("abort_done", o_tx_done, 0);
      repeat (2) @(negedge clk);
      rst_n = 1;
      frame(8'h5A, 8, 2'b00, 0, "0010110101", 160);
      repeat (5) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/uart_tx_cfg.md
# uart_tx_cfg

Runtime-configurable UART transmitter for the calculator's serial output path, successor to the fixed 8N1 transmitter. It accepts a byte over a valid/ready handshake and serialises it LSB-first, paced by the shared baud oversampling tick. Data length (5..DATA_BITS), parity (none/even/odd) and stop bits (1/2) are selectable per frame. It sits between the result formatter and the TX pin.

## Interface
- DATA_BITS, 8, maximum data bits per frame; must be at least 5.
- TICKS_PER_BIT, 16, i_tick_en pulses per bit period; must be at least 2.
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_tick_en  in  1  oversampling tick, one-cycle strobe.
- i_valid  in  1  i_data and i_cfg_* are presented.
- o_ready  out  1  transmitter can accept a frame.
- i_data  in  DATA_BITS  payload; only the low i_cfg_len bits are sent.
- i_cfg_len  in  $clog2(DATA_BITS+1)  data bit count; below 5 clamps to 5, above DATA_BITS clamps to DATA_BITS.
- i_cfg_parity  in  2  00 none, 01 even, 10 odd, 11 treated as none.
- i_cfg_stop  in  1  0 = one stop bit, 1 = two stop bits.
- o_tx  out  1  serial line, idle high.
- o_busy  out  1  a frame is in progress (any state except IDLE).
- o_tx_done  out  1  one-cycle pulse at the end of the last stop bit.

## Operation
- The frame is accepted on the rising edge where i_valid && o_ready. i_data, clamped length, parity mode and stop count are latched into frame registers. Inputs changing afterwards have no effect on the current frame.
- States:
  - IDLE: o_tx=1, o_ready=1. On accept, go to START and clear the tick and bit counters.
  - START: o_tx=0. After TICKS_PER_BIT ticks, go to DATA.
  - DATA: o_tx = shift register bit 0. Each bit lasts TICKS_PER_BIT ticks, then the register shifts right. After the latched-length bit, go to PARITY if the parity mode is even or odd, otherwise to STOP.
  - PARITY: o_tx = XOR of the sent data bits (even mode), or its inverse (odd mode). Lasts one bit period, then go to STOP.
  - STOP: o_tx=1 for 1 or 2 bit periods. At the final tick, pulse o_tx_done and go to IDLE.
- Parity is accumulated as bits shift out; it is not recomputed from i_data.
- Frame duration is TICKS_PER_BIT × (1 + len + p + stop) ticks, where p is 0 or 1.
- i_tick_en low freezes all counters; state changes only on tick cycles, except the IDLE→START transition on accept.
- o_ready is low whenever o_busy is high. The design has no input buffering.

## Timing
- Reset (asynchronous, while i_rst_n=0): state IDLE, all counters 0, shift register 0, o_tx=1, o_ready=1, o_busy=0, o_tx_done=0. Outputs take these values immediately.
- Reset asserted mid-frame aborts the frame. o_tx returns high without any glitch to 0, and no o_tx_done is produced.
- Accept latency: o_tx falls in the first clock after the accepting edge.
- o_tx_done is high in the same cycle as the final stop tick. o_ready returns high the following clock.
- Back-to-back with i_valid held high: the next frame is accepted on the first IDLE cycle. The line stays high for the full stop time plus exactly one clock.
- A tick coinciding with the accept cycle is not counted toward START.
- o_tx, o_ready and o_busy are decoded from registered state only. i_valid and i_data have no combinational path to any output.

## Configuration
- UART_TX_PARITY_EN defined: parity logic, the PARITY state and the i_cfg_parity latch are present, and operation is as described above.
- UART_TX_PARITY_EN undefined: i_cfg_parity is ignored, the PARITY state and parity accumulator are not synthesised, and every frame goes DATA→STOP. The port list is unchanged.

## Structure
- Shared package uart_pkg holds:
  - state encodings: IDLE, START, DATA, PARITY, STOP (3 bits);
  - parity codes: PAR_NONE, PAR_EVEN, PAR_ODD;
  - the UART_MIN_DATA_BITS=5 constant.
- One sub-module, uart_tx_bit_timer:
  - counts i_tick_en up to TICKS_PER_BIT-1;
  - emits a one-cycle o_bit_end pulse;
  - is synchronously cleared by i_clr.
- The transmitter FSM counts bit_end pulses for data bits and stop bits.

## Test plan
- Reset: hold i_rst_n=0 with i_valid=1 -> o_tx=1, o_ready=1, o_busy=0, o_tx_done=0. Assert i_rst_n=0 mid-DATA -> o_tx=1 at once; after release, a new frame sends correctly.
- Frame 0xA5, len 8, no parity, 1 stop, TICKS_PER_BIT=16, tick every clock -> o_tx is 0,1,0,1,0,0,1,0,1,1 for 16 clocks each, and o_tx_done pulses 160 clocks after accept+1.
- Frame 0x53, len 7, even parity -> data bits 1,1,0,0,1,0,1, then parity bit 0. Repeat with odd parity -> parity bit 1. Without UART_TX_PARITY_EN -> no parity bit, 9-bit frame.
- Frame 0xFF, len 5, 2 stops, tick every 4th clock -> 0,1,1,1,1,1, then high for 32 ticks. o_tx_done arrives 128 ticks after start. Repeat with i_cfg_len=3 -> clamped to 5, identical waveform.
- Back-to-back 0x31 and 0x32 with i_valid held, and i_cfg_len changed to 6 during frame 1 -> frame 1 uses len 8, frame 2 uses len 6, with exactly one idle clock between frames.
- Tick pause: hold i_tick_en low for 100 clocks mid-bit -> o_tx holds its value, and the bit completes after the remaining ticks.
